// File: rtl/serial_adder.sv
// Bit-serial adder: one full-adder cell plus a carry flop, one bit per clock.
// Start/busy/done handshake; the result is held until the next op completes.
module serial_adder #(
    parameter int WIDTH  = 8,
    parameter bit SIGNED = 1'b0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic {IDLE, RUN} state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] s_q, s_d;
    logic             carry_q, carry_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic             cout_q, cout_d;
    logic             ovf_q, ovf_d;
    logic             done_q, done_d;
    logic             bit_s, bit_c;

    assign bit_s = a_q[0] ^ b_q[0] ^ carry_q;
    assign bit_c = (a_q[0] & b_q[0]) | (carry_q & (a_q[0] ^ b_q[0]));

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        s_d     = s_q;
        carry_d = carry_q;
        cnt_d   = cnt_q;
        sum_d   = sum_q;
        cout_d  = cout_q;
        ovf_d   = ovf_q;
        done_d  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    a_d     = a;
                    b_d     = b;
                    carry_d = cin;
                    cnt_d   = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                a_d     = a_q >> 1;
                b_d     = b_q >> 1;
                s_d     = {bit_s, s_q[WIDTH-1:1]};
                carry_d = bit_c;
                cnt_d   = cnt_q + CW'(1);
                if (cnt_q == LAST) begin
                    // carry_q is the carry into the MSB on this final step
                    sum_d   = {bit_s, s_q[WIDTH-1:1]};
                    cout_d  = bit_c;
                    ovf_d   = SIGNED ? (carry_q ^ bit_c) : bit_c;
                    done_d  = 1'b1;
                    cnt_d   = '0;
                    state_d = IDLE;
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            s_q     <= '0;
            carry_q <= 1'b0;
            cnt_q   <= '0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            s_q     <= s_d;
            carry_q <= carry_d;
            cnt_q   <= cnt_d;
            sum_q   <= sum_d;
            cout_q  <= cout_d;
            ovf_q   <= ovf_d;
            done_q  <= done_d;
        end
    end

    assign busy = (state_q == RUN);
    assign done = done_q;
    assign sum  = sum_q;
    assign cout = cout_q;
    assign ovf  = ovf_q;

endmodule

// File: tb/tb_serial_adder.sv
// Self-checking bench for serial_adder: 8-bit unsigned/signed and 3-bit
// instances, table vectors, random ops vs. an arithmetic model, corner cases.
module tb_serial_adder;

    logic       clk;
    logic       rst_n;
    logic       start8, cin8;
    logic [7:0] a8, b8;
    logic       busy8, done8, cout8, ovf8;
    logic [7:0] sum8;
    logic       busyS, doneS, coutS, ovfS;
    logic [7:0] sumS;
    logic       start3, cin3;
    logic [2:0] a3, b3;
    logic       busy3, done3, cout3, ovf3;
    logic [2:0] sum3;

    int n_chk = 0;
    int n_fail = 0;
    int dcnt8 = 0;
    int dcnt3 = 0;

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic       c;
        logic [7:0] s;
        logic       co;
        logic       ou;
        logic       os;
    } vec_t;

    serial_adder #(.WIDTH(8), .SIGNED(1'b0)) u_u8 (
        .clk(clk), .rst_n(rst_n), .start(start8), .a(a8), .b(b8),
        .cin(cin8), .busy(busy8), .done(done8), .sum(sum8),
        .cout(cout8), .ovf(ovf8)
    );

    serial_adder #(.WIDTH(8), .SIGNED(1'b1)) u_s8 (
        .clk(clk), .rst_n(rst_n), .start(start8), .a(a8), .b(b8),
        .cin(cin8), .busy(busyS), .done(doneS), .sum(sumS),
        .cout(coutS), .ovf(ovfS)
    );

    serial_adder #(.WIDTH(3), .SIGNED(1'b0)) u_u3 (
        .clk(clk), .rst_n(rst_n), .start(start3), .a(a3), .b(b3),
        .cin(cin3), .busy(busy3), .done(done3), .sum(sum3),
        .cout(cout3), .ovf(ovf3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (done8 === 1'b1) dcnt8++;
        if (done3 === 1'b1) dcnt3++;
    end

    task automatic chk(input string nm, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, got, exp);
        end
    endtask

    function automatic vec_t ref_model(input logic [7:0] ta,
                                       input logic [7:0] tb,
                                       input logic tc);
        vec_t v;
        int   full;
        int   sv;
        full = int'(ta) + int'(tb) + int'(tc);
        sv   = int'($signed(ta)) + int'($signed(tb)) + int'(tc);
        v.a  = ta;
        v.b  = tb;
        v.c  = tc;
        v.s  = full[7:0];
        v.co = full[8];
        v.ou = full[8];
        v.os = (sv > 127) || (sv < -128);
        return v;
    endfunction

    task automatic run8(input vec_t v, input string nm);
        int cyc;
        int nb;
        @(negedge clk);
        a8 = v.a; b8 = v.b; cin8 = v.c; start8 = 1'b1;
        @(negedge clk);
        start8 = 1'b0;
        a8 = 8'($urandom); b8 = 8'($urandom); cin8 = 1'($urandom);
        cyc = 0;
        nb  = 0;
        while (!done8 && cyc < 20) begin
            if (busy8) nb++;
            @(negedge clk);
            cyc++;
        end
        chk({nm, " latency"}, cyc, 8);
        chk({nm, " busy_cycles"}, nb, 8);
        chk({nm, " busy_at_done"}, {31'd0, busy8}, 0);
        chk({nm, " doneS"}, {31'd0, doneS}, 1);
        chk({nm, " sum"}, {24'd0, sum8}, {24'd0, v.s});
        chk({nm, " cout"}, {31'd0, cout8}, {31'd0, v.co});
        chk({nm, " ovf_u"}, {31'd0, ovf8}, {31'd0, v.ou});
        chk({nm, " sumS"}, {24'd0, sumS}, {24'd0, v.s});
        chk({nm, " coutS"}, {31'd0, coutS}, {31'd0, v.co});
        chk({nm, " ovf_s"}, {31'd0, ovfS}, {31'd0, v.os});
    endtask

    initial begin
        vec_t tbl[8];
        vec_t v;
        logic [3:0] prev3;
        logic [3:0] exp3;
        int cyc;
        int d0;

        tbl[0] = '{8'h0F, 8'h01, 1'b0, 8'h10, 1'b0, 1'b0, 1'b0};
        tbl[1] = '{8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0};
        tbl[2] = '{8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b0, 1'b1};
        tbl[3] = '{8'h12, 8'h34, 1'b0, 8'h46, 1'b0, 1'b0, 1'b0};
        tbl[4] = '{8'h80, 8'h80, 1'b0, 8'h00, 1'b1, 1'b1, 1'b1};
        tbl[5] = '{8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1, 1'b1, 1'b0};
        tbl[6] = '{8'h00, 8'h00, 1'b1, 8'h01, 1'b0, 1'b0, 1'b0};
        tbl[7] = '{8'h7F, 8'h00, 1'b1, 8'h80, 1'b0, 1'b0, 1'b1};

        rst_n = 1'b0;
        start8 = 1'b0; a8 = 8'h0; b8 = 8'h0; cin8 = 1'b0;
        start3 = 1'b0; a3 = 3'h0; b3 = 3'h0; cin3 = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst busy", {31'd0, busy8}, 0);
        chk("rst done", {31'd0, done8}, 0);
        chk("rst sum", {24'd0, sum8}, 0);
        chk("rst cout", {31'd0, cout8}, 0);
        chk("rst ovf", {31'd0, ovf8}, 0);
        chk("rst sum3", {29'd0, sum3}, 0);
        rst_n = 1'b1;

        for (int i = 0; i < 8; i++)
            run8(tbl[i], $sformatf("tbl%0d", i));

        for (int i = 0; i < 20; i++) begin
            v = ref_model(8'($urandom), 8'($urandom), 1'($urandom));
            run8(v, $sformatf("rnd%0d", i));
        end

        // Exhaustive 3-bit, each new op started in the previous done cycle
        prev3 = 4'h0;
        @(negedge clk);
        a3 = 3'd0; b3 = 3'd0; cin3 = 1'b0; start3 = 1'b1;
        for (int i = 0; i < 128; i++) begin
            exp3 = 4'(a3) + 4'(b3) + 4'(cin3);
            @(negedge clk);
            start3 = 1'b0;
            chk($sformatf("w3 hold%0d", i), {28'd0, cout3, sum3},
                {28'd0, prev3});
            cyc = 0;
            while (!done3 && cyc < 10) begin
                @(negedge clk);
                cyc++;
            end
            chk($sformatf("w3 lat%0d", i), cyc, 3);
            chk($sformatf("w3 res%0d", i), {28'd0, cout3, sum3},
                {28'd0, exp3});
            prev3 = exp3;
            if (i < 127) begin
                a3 = 3'((i + 1) >> 4);
                b3 = 3'((i + 1) >> 1);
                cin3 = 1'((i + 1) & 1);
                start3 = 1'b1;
            end
        end
        repeat (6) @(negedge clk);
        chk("w3 done count", dcnt3, 128);

        // Start pulse while busy must be ignored
        @(negedge clk);
        a8 = 8'h12; b8 = 8'h34; cin8 = 1'b0; start8 = 1'b1;
        @(negedge clk);
        start8 = 1'b0;
        d0 = dcnt8;
        repeat (2) @(negedge clk);
        a8 = 8'hFF; b8 = 8'hFF; cin8 = 1'b1; start8 = 1'b1;
        @(negedge clk);
        start8 = 1'b0;
        cyc = 0;
        while (!done8 && cyc < 20) begin
            @(negedge clk);
            cyc++;
        end
        chk("ign latency", cyc, 5);
        chk("ign sum", {24'd0, sum8}, 32'h46);
        repeat (12) @(negedge clk);
        chk("ign single done", dcnt8 - d0, 1);
        chk("ign idle", {31'd0, busy8}, 0);

        // Reset mid-operation discards the op without a done pulse
        @(negedge clk);
        a8 = 8'h01; b8 = 8'h01; cin8 = 1'b0; start8 = 1'b1;
        @(negedge clk);
        start8 = 1'b0;
        d0 = dcnt8;
        repeat (3) @(negedge clk);
        chk("rst6 hold sum", {24'd0, sum8}, 32'h46);
        chk("rst6 busy pre", {31'd0, busy8}, 1);
        #2 rst_n = 1'b0;
        #1;
        chk("rst6 busy", {31'd0, busy8}, 0);
        chk("rst6 done", {31'd0, done8}, 0);
        chk("rst6 sum", {24'd0, sum8}, 0);
        chk("rst6 cout", {31'd0, cout8}, 0);
        chk("rst6 ovf", {31'd0, ovf8}, 0);
        chk("rst6 sumS", {24'd0, sumS}, 0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (12) @(negedge clk);
        chk("rst6 no done", dcnt8 - d0, 0);
        chk("rst6 idle", {31'd0, busy8}, 0);
        run8(ref_model(8'h05, 8'h03, 1'b1), "post_rst");

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
